// File: rtl/count_chk_pkg.sv
// Shared encodings and defaults for the counter-sequence checker.
package count_chk_pkg;
  localparam int COUNT_W      = 3;
  localparam int RUN_W        = 4;
  localparam int LOCK_LEN_DEF = 4;
  localparam int ERR_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Modulo-8 successor of a counter value.
  function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] v);
    return v + 1'b1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Event counter that either saturates at all-ones or wraps, chosen by sat_mode.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !(sat_mode && (cnt_q == '1)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/count_checker.sv
// Checks that an upstream 3-bit counter increments by one each enabled cycle,
// training to lock after LOCK_LEN good steps and reporting wraps/mismatches.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int LOCK_LEN = LOCK_LEN_DEF,
  parameter int ERR_W    = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       count,
  output logic             locked,
  output logic             wrap,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [1:0]       state
);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d, run_inc;
  logic               locked_q, locked_d;
  logic               wrap_q, wrap_d;
  logic               mismatch_q, mismatch_d;
  logic               err_inc, wrap_inc, pass;

  assign pass    = (count == next_count(prev_q));
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    locked_d   = locked_q;
    wrap_d     = 1'b0;
    mismatch_d = 1'b0;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;
    if (!en) begin
      // prev is deliberately held so the next enabled sample only reseeds it
      state_d  = IDLE;
      run_d    = '0;
      locked_d = 1'b0;
    end else begin
      prev_d = count;
      case (state_q)
        IDLE: begin
          state_d = TRAIN;
          run_d   = '0;
        end
        TRAIN: begin
          if (!pass) begin
            run_d = '0;
          end else if (run_inc == LOCK_RUN) begin
            state_d  = LOCKED;
            run_d    = '0;
            locked_d = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        LOCKED: begin
          if (pass) begin
            if (prev_q == '1) begin
              wrap_d   = 1'b1;
              wrap_inc = 1'b1;
            end
          end else begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = TRAIN;
            run_d      = '0;
            locked_d   = 1'b0;
          end
        end
        default: begin
          state_d  = IDLE;
          run_d    = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      wrap_q     <= wrap_d;
      mismatch_q <= mismatch_d;
    end
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .inc      (err_inc),
    .sat_mode (1'b1),
    .cnt      (err_count)
  );

  sat_counter #(.WIDTH(ERR_W)) u_wrap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .inc      (wrap_inc),
    .sat_mode (1'b0),
    .cnt      (wrap_count)
  );

  assign locked   = locked_q;
  assign wrap     = wrap_q;
  assign mismatch = mismatch_q;
  assign state    = state_q;
endmodule

// File: tb/tb_count_checker.sv
// Directed scoreboard bench: two checkers (ERR_W=8 and ERR_W=2) share stimulus.
module tb_count_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] count = 3'd0;

  logic       locked_a, wrap_a, mismatch_a;
  logic [7:0] err_a, wc_a;
  logic [1:0] state_a;
  logic       locked_b, wrap_b, mismatch_b;
  logic [1:0] err_b, wc_b;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_vec    = 0;

  typedef struct {
    int st; int lk; int wr; int mi; int er; int er2; int wc; int wc2;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  count_checker #(.LOCK_LEN(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .locked(locked_a), .wrap(wrap_a), .mismatch(mismatch_a),
    .err_count(err_a), .wrap_count(wc_a), .state(state_a)
  );

  count_checker #(.LOCK_LEN(4), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .locked(locked_b), .wrap(wrap_b), .mismatch(mismatch_b),
    .err_count(err_b), .wrap_count(wc_b), .state(state_b)
  );

  function automatic void chk(input int idx, input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, nm, act, expv);
    end
  endfunction

  // Inputs change on the falling edge, like the upstream counter.
  task automatic v(input logic r, input logic e, input int c,
                   input int st, input int lk, input int wr, input int mi,
                   input int er, input int er2, input int wc, input int wc2);
    exp_t x;
    @(negedge clk);
    rst   = r;
    en    = e;
    count = c[2:0];
    x = '{st, lk, wr, mi, er, er2, wc, wc2};
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk(n_vec, "state",     int'(state_a),    x.st);
        chk(n_vec, "locked",    int'(locked_a),   x.lk);
        chk(n_vec, "wrap",      int'(wrap_a),     x.wr);
        chk(n_vec, "mismatch",  int'(mismatch_a), x.mi);
        chk(n_vec, "err_count", int'(err_a),      x.er);
        chk(n_vec, "wrap_cnt",  int'(wc_a),       x.wc);
        chk(n_vec, "err2",      int'(err_b),      x.er2);
        chk(n_vec, "wrap_cnt2", int'(wc_b),       x.wc2);
        chk(n_vec, "state2",    int'(state_b),    x.st);
        chk(n_vec, "mismatch2", int'(mismatch_b), x.mi);
        n_vec++;
      end
    end
  end

  initial begin : driver
    // reset, then idle after release
    v(1,0,0, 0,0,0,0, 0,0,0,0);
    v(1,0,0, 0,0,0,0, 0,0,0,0);
    v(0,0,0, 0,0,0,0, 0,0,0,0);
    // train 0..4 and lock on 4
    v(0,1,0, 1,0,0,0, 0,0,0,0);
    v(0,1,1, 1,0,0,0, 0,0,0,0);
    v(0,1,2, 1,0,0,0, 0,0,0,0);
    v(0,1,3, 1,0,0,0, 0,0,0,0);
    v(0,1,4, 2,1,0,0, 0,0,0,0);
    // locked wrap 7->0
    v(0,1,5, 2,1,0,0, 0,0,0,0);
    v(0,1,6, 2,1,0,0, 0,0,0,0);
    v(0,1,7, 2,1,0,0, 0,0,0,0);
    v(0,1,0, 2,1,1,0, 0,0,1,1);
    v(0,1,1, 2,1,0,0, 0,0,1,1);
    // skip 3->5, then relock through 6,7,0,1 (no wrap in TRAIN)
    v(0,1,2, 2,1,0,0, 0,0,1,1);
    v(0,1,3, 2,1,0,0, 0,0,1,1);
    v(0,1,5, 1,0,0,1, 1,1,1,1);
    v(0,1,6, 1,0,0,0, 1,1,1,1);
    v(0,1,7, 1,0,0,0, 1,1,1,1);
    v(0,1,0, 1,0,0,0, 1,1,1,1);
    v(0,1,1, 2,1,0,0, 1,1,1,1);
    // held value
    v(0,1,2, 2,1,0,0, 1,1,1,1);
    v(0,1,3, 2,1,0,0, 1,1,1,1);
    v(0,1,3, 1,0,0,1, 2,2,1,1);
    v(0,1,4, 1,0,0,0, 2,2,1,1);
    v(0,1,5, 1,0,0,0, 2,2,1,1);
    v(0,1,6, 1,0,0,0, 2,2,1,1);
    v(0,1,7, 2,1,0,0, 2,2,1,1);
    // held 7; TRAIN failure leaves err alone; lock on a 7->0 pass without wrap
    v(0,1,7, 1,0,0,1, 3,3,1,1);
    v(0,1,4, 1,0,0,0, 3,3,1,1);
    v(0,1,5, 1,0,0,0, 3,3,1,1);
    v(0,1,6, 1,0,0,0, 3,3,1,1);
    v(0,1,7, 1,0,0,0, 3,3,1,1);
    v(0,1,0, 2,1,0,0, 3,3,1,1);
    v(0,1,1, 2,1,0,0, 3,3,1,1);
    // further mismatches: 2-bit counter saturates at 3
    v(0,1,3, 1,0,0,1, 4,3,1,1);
    v(0,1,4, 1,0,0,0, 4,3,1,1);
    v(0,1,5, 1,0,0,0, 4,3,1,1);
    v(0,1,6, 1,0,0,0, 4,3,1,1);
    v(0,1,7, 2,1,0,0, 4,3,1,1);
    v(0,1,1, 1,0,0,1, 5,3,1,1);
    v(0,1,2, 1,0,0,0, 5,3,1,1);
    v(0,1,3, 1,0,0,0, 5,3,1,1);
    v(0,1,4, 1,0,0,0, 5,3,1,1);
    v(0,1,5, 2,1,0,0, 5,3,1,1);
    v(0,1,6, 2,1,0,0, 5,3,1,1);
    v(0,1,7, 2,1,0,0, 5,3,1,1);
    v(0,1,0, 2,1,1,0, 5,3,2,2);
    v(0,1,1, 2,1,0,0, 5,3,2,2);
    v(0,1,2, 2,1,0,0, 5,3,2,2);
    // enable dropped for 3 cycles while count jumps
    v(0,0,3, 0,0,0,0, 5,3,2,2);
    v(0,0,4, 0,0,0,0, 5,3,2,2);
    v(0,0,6, 0,0,0,0, 5,3,2,2);
    v(0,1,6, 1,0,0,0, 5,3,2,2);
    v(0,1,7, 1,0,0,0, 5,3,2,2);
    v(0,1,0, 1,0,0,0, 5,3,2,2);
    v(0,1,1, 1,0,0,0, 5,3,2,2);
    v(0,1,2, 2,1,0,0, 5,3,2,2);
    // two more wraps: 2-bit wrap counter rolls over to 0
    for (int k = 3; k < 8; k++) v(0,1,k, 2,1,0,0, 5,3,2,2);
    v(0,1,0, 2,1,1,0, 5,3,3,3);
    for (int k = 1; k < 8; k++) v(0,1,k, 2,1,0,0, 5,3,3,3);
    v(0,1,0, 2,1,1,0, 5,3,4,0);
    v(0,1,1, 2,1,0,0, 5,3,4,0);
    // reset wins over en mid-LOCKED
    v(1,1,2, 0,0,0,0, 0,0,0,0);
    v(0,0,2, 0,0,0,0, 0,0,0,0);
    v(0,1,5, 1,0,0,0, 0,0,0,0);
    v(0,1,6, 1,0,0,0, 0,0,0,0);

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter LOCK_LEN, default 4: consecutive correct increments needed to enter LOCKED; legal range 1..15.
REQ-002 Parameter ERR_W, default 8: width of err_count and wrap_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  check enable; low = block idles.
REQ-006 count  input  3  value from the upstream 3-bit counter, which updates on the falling edge of clk.
REQ-007 locked  output  1  high while state is LOCKED.
REQ-008 wrap  output  1  one-cycle pulse on a checked 7->0 transition while LOCKED.
REQ-009 mismatch  output  1  one-cycle pulse on a failed check while LOCKED.
REQ-010 err_count  output  ERR_W  saturating count of mismatch pulses.
REQ-011 wrap_count  output  ERR_W  modulo-2^ERR_W count of wrap pulses.
REQ-012 state  output  2  current FSM state (IDLE=0, TRAIN=1, LOCKED=2).

Function
REQ-013 The block SHALL sample count on every rising edge with en=1 into register prev; the check compares the new sample against prev before prev updates.
REQ-014 A check SHALL pass iff count == (prev + 1) mod 8; 7->0 passes; a held value (count == prev) and any skip fail.
REQ-015 In IDLE with en=1: capture prev and go to TRAIN with run=0; no check is made.
REQ-016 In TRAIN: pass increments run; fail clears run to 0 and stays in TRAIN; when a pass makes run equal LOCK_LEN, go to LOCKED and clear run.
REQ-017 In LOCKED: pass stays LOCKED; fail pulses mismatch, increments err_count, and goes to TRAIN with run=0.
REQ-018 wrap SHALL pulse only for a passing 7->0 check taken in LOCKED; a 7->0 pass that causes the TRAIN->LOCKED transition SHALL NOT pulse wrap.
REQ-019 mismatch and wrap SHALL be registered, high for exactly the one cycle after the rising edge that made the check.
REQ-020 locked and state SHALL be registered and change on the same edge as the transition.
REQ-021 err_count SHALL saturate at 2^ERR_W-1; wrap_count SHALL roll over to 0.
REQ-022 en=0 at a rising edge: go to IDLE, clear run and locked, force wrap and mismatch low, make no check, and hold err_count and wrap_count.
REQ-023 prev SHALL NOT be updated while en=0; the first sample after en returns only seeds prev.
REQ-024 TRAIN makes no mismatch or wrap pulses, and failures there do not change err_count.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, prev=0, run=0, locked=0, wrap=0, mismatch=0, err_count=0, wrap_count=0.
REQ-026 rst SHALL take priority over en and over any check in progress, including mid-LOCKED.
REQ-027 Outputs SHALL hold reset values in the cycle after rst deasserts until the first sampled edge with en=1.

Structure
REQ-028 Package count_chk_pkg SHALL hold the state encoding (IDLE, TRAIN, LOCKED), COUNT_W=3, and the default LOCK_LEN and ERR_W.
REQ-029 One sub-module, sat_counter (parameter width, inputs inc/clr, a saturate/wrap mode select), SHALL implement both err_count and wrap_count.
REQ-030 The run counter SHALL be 4 bits wide; the FSM, prev and run SHALL live in count_checker.

Verification
REQ-031 rst, then en=1, count 0,1,2,3,4 on successive cycles -> state TRAIN, then locked=1 on the edge sampling 4; no pulses.
REQ-032 While LOCKED, count ...6,7,0,1 -> one-cycle wrap on the 7->0 edge; wrap_count=1.
REQ-033 While LOCKED, count 2,3,5 -> mismatch pulse after the edge sampling 5, err_count=1, state=TRAIN; then 6,7,0,1 -> relock (LOCK_LEN=4).
REQ-034 While LOCKED, count held at 3 for two samples -> mismatch, err_count increments by 1, and the block returns to TRAIN.
REQ-035 ERR_W=2: force 5 lock/mismatch cycles -> err_count stops at 3.
REQ-036 en dropped for 3 cycles while LOCKED and count jumps 2->6 -> IDLE, locked=0, no mismatch, err_count unchanged; on en=1 with 6,7,0,1,2 -> relock after 4 passes.
